serial_addsub: RTL
==================

// Module: serial_addsub
// PURPOSE
//   Bit-serial WIDTH-bit adder/subtractor controller that drives the one-bit adder slice
//   (ports A, B, CI, CO, S, E) one bit per clock, LSB first, through an internal instance.
//   Holds operand shift registers, a carry flop and a bit counter, and assembles the serial
//   sum bits into a parallel result. Trades WIDTH cycles of latency for a single slice;
//   used where area matters more than throughput.
// PARAMETERS
//   WIDTH   8   operand/result width in bits (>=2)
// PORTS
//   clk       in   1      rising-edge clock; single clock domain
//   reset_n   in   1      asynchronous, active-low reset
//   start     in   1      request; sampled only in IDLE
//   a         in   WIDTH  operand A, captured when start is accepted
//   b         in   WIDTH  operand B, captured when start is accepted
//   sub       in   1      0: A+B, 1: A-B; captured with the operands
//   busy      out  1      high while bits are being processed (RUN)
//   done      out  1      one-cycle pulse: result valid
//   sum       out  WIDTH  result, two's-complement / modulo 2^WIDTH
//   cout      out  1      final carry; for subtract 1 = no borrow (A>=B unsigned)
//   overflow  out  1      signed overflow = carry into MSB XOR carry out of MSB
// BEHAVIOUR
//   - Reset (async assert, sync release): state=IDLE; busy, done, cout, overflow = 0;
//     sum = 0; shift regs, carry, counter = 0.
//   - States: IDLE -> RUN on start; RUN -> DONE after WIDTH bit-cycles; DONE -> IDLE
//     unconditionally on the next edge.
//   - Accept (edge k, IDLE, start=1): latch a, b, sub; carry <= sub (the +1 of two's-
//     complement subtract); count <= 0; state <= RUN.
//   - RUN edges k+1 .. k+WIDTH: slice inputs A=a_sh[0], B=b_sh[0], CI=carry, E=sub_q.
//     Slice S shifts into the result-register MSB (register shifts right); carry <= CO;
//     a_sh, b_sh shift right; count++. On the edge processing bit WIDTH-1, record the
//     slice CI (carry into MSB) for overflow.
//   - Edge k+WIDTH: state <= DONE; sum, cout, overflow update; done=1 for exactly that
//     one cycle. busy is high from after edge k through edge k+WIDTH, low in DONE.
//   - Latency: start-sampling edge to done rising = WIDTH edges; next start is accepted
//     no earlier than edge k+WIDTH+2 (one IDLE cycle).
//   - start in RUN or DONE is ignored (not queued). Changes to a, b, sub after accept
//     have no effect on the operation in flight.
//   - sum/cout/overflow hold their last values until the next completed operation; they
//     are not cleared on accept.
//   - Reset mid-operation: abort immediately, all outputs to reset values, no done pulse.
//   - Counter wraps only via the RUN->DONE exit; no state other than the three exists.
//     Illegal encodings go to IDLE.
// TESTING (WIDTH=8)
//   1 add 100+27 -> done 8 edges after accept; sum=127, cout=0, overflow=0
//   2 add 200+100 -> sum=44, cout=1; add 127+1 -> sum=128 (0x80), overflow=1, cout=0
//   3 sub 5-7 -> sum=0xFE, cout=0, overflow=0; sub 7-5 -> sum=2, cout=1
//   4 sub 0x80-1 -> sum=0x7F, overflow=1, cout=1; sub 0-0 -> sum=0, cout=1, overflow=0
//   5 start pulsed every cycle with changing a/b during RUN -> one result, first
//     operands only; done exactly one cycle wide; busy low in DONE
//   6 reset_n low at bit 3 of 100+27 -> busy, done, sum, cout, overflow = 0 immediately;
//     after release, new op 1+1 -> sum=2

Source files
------------

// File: rtl/serial_addsub_if.sv
// ---------------------------------------------------------------------------
// serial_addsub_if
//   Groups the request/result signals of the bit-serial adder/subtractor.
//   Handshake: the requester raises start with a, b and sub stable; the
//   controller takes them on a rising clk edge only while idle (busy=0 and
//   done=0). start seen at any other time is dropped, not queued. done is a
//   one-cycle pulse; sum/cout/overflow are valid from it and hold until the
//   next operation completes.
//   Signals:
//     start      request (master -> slave)
//     a, b       WIDTH-bit operands (master -> slave)
//     sub        0: a+b, 1: a-b (master -> slave)
//     busy       bits being processed (slave -> master)
//     done       one-cycle result-valid pulse (slave -> master)
//     sum        WIDTH-bit result, modulo 2^WIDTH (slave -> master)
//     cout       final carry; for subtract 1 = no borrow (slave -> master)
//     overflow   signed overflow (slave -> master)
//     state_dbg  controller state encoding for observation (slave -> master)
// ---------------------------------------------------------------------------
interface serial_addsub_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             sub;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             overflow;
   logic [1:0]       state_dbg;

   modport master (
      output start, a, b, sub,
      input  busy, done, sum, cout, overflow, state_dbg
   );

   modport slave (
      input  start, a, b, sub,
      output busy, done, sum, cout, overflow, state_dbg
   );
endinterface

// File: rtl/serial_addsub.sv
// ---------------------------------------------------------------------------
// serial_addsub
//   Bit-serial WIDTH-bit adder/subtractor. One single-bit slice is reused
//   for every bit, LSB first, one bit per clock. Operands sit in shift
//   registers, the slice carry is kept in a flop, and the serial sum bits
//   are collected into a parallel result.
//   Ports:
//     clk      rising-edge clock
//     reset_n  asynchronous active-low reset
//     bus      serial_addsub_if slave: start/a/b/sub in,
//              busy/done/sum/cout/overflow/state_dbg out
//   Timing: start accepted on edge k (IDLE); bits processed on edges
//   k+1..k+WIDTH; done high for the cycle after edge k+WIDTH; back to IDLE
//   on the following edge.
// ---------------------------------------------------------------------------
module serial_addsub #(
   parameter int WIDTH = 8
) (
   input logic           clk,
   input logic           reset_n,
   serial_addsub_if.slave bus
);
   localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_next;

   logic [WIDTH-1:0] r_a_sh;
   logic [WIDTH-1:0] r_b_sh;
   logic             r_sub;
   logic             r_carry;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_res;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;
   logic             r_ovf;

   logic             w_s;
   logic             w_co;
   logic             w_last;
   logic             w_busy;
   logic             w_done;

   // E inverts B inside the slice; with carry seeded to 1 this gives A + ~B + 1.
   addsub_slice u_slice (
      .A  (r_a_sh[0]),
      .B  (r_b_sh[0]),
      .CI (r_carry),
      .E  (r_sub),
      .CO (w_co),
      .S  (w_s)
   );

   assign w_last = (r_cnt == LAST_BIT);

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next state and state-decoded outputs
   always_comb begin
      w_next = S_IDLE;
      w_busy = 1'b0;
      w_done = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_next = bus.start ? S_RUN : S_IDLE;
         end
         S_RUN: begin
            w_busy = 1'b1;
            w_next = w_last ? S_DONE : S_RUN;
         end
         S_DONE: begin
            w_done = 1'b1;
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // Datapath
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_a_sh  <= '0;
         r_b_sh  <= '0;
         r_sub   <= 1'b0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
         r_res   <= '0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_a_sh  <= bus.a;
                  r_b_sh  <= bus.b;
                  r_sub   <= bus.sub;
                  r_carry <= bus.sub;
                  r_cnt   <= '0;
               end
            end
            S_RUN: begin
               r_a_sh  <= r_a_sh >> 1;
               r_b_sh  <= r_b_sh >> 1;
               r_carry <= w_co;
               r_res   <= {w_s, r_res[WIDTH-1:1]};
               if (w_last) begin
                  // r_carry here is the carry into the MSB.
                  r_sum  <= {w_s, r_res[WIDTH-1:1]};
                  r_cout <= w_co;
                  r_ovf  <= r_carry ^ w_co;
                  r_cnt  <= '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.busy      = w_busy;
   assign bus.done      = w_done;
   assign bus.sum       = r_sum;
   assign bus.cout      = r_cout;
   assign bus.overflow  = r_ovf;
   assign bus.state_dbg = r_state;
endmodule

// ---------------------------------------------------------------------------
// addsub_slice
//   One-bit full adder with B-invert.
//   Ports: A, B operand bits; CI carry in; E invert B (subtract);
//          S sum bit; CO carry out.
// ---------------------------------------------------------------------------
module addsub_slice (
   input  logic A,
   input  logic B,
   input  logic CI,
   input  logic E,
   output logic CO,
   output logic S
);
   logic w_b;

   assign w_b = B ^ E;
   assign S   = A ^ w_b ^ CI;
   assign CO  = (A & w_b) | (CI & (A ^ w_b));
endmodule
